multdiv_unit: RTL and testbench

Parametrised iterative signed multiply/divide execution unit for the pipelined processor's X stage. It accepts one operation at a time with a destination-register tag, runs in the background while the pipeline stalls or proceeds, and holds its result until the writeback port grants it. It provides flush/kill, exception reporting, and back-to-back issue.

---
 rtl/multdiv_pkg.sv | 21 ++
 rtl/multdiv_abs.sv | 15 +
 rtl/multdiv_unit.sv | 190 +++++++++++++++++++
 tb/tb_multdiv_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared encodings and helpers for the iterative signed multiply/divide unit.
// Latency: none (declarations only).
// Backpressure: not applicable.
package multdiv_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Width of the iteration counter; it only has to hold WIDTH-1.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/multdiv_abs.sv
// Two's-complement conditional negate; with neg tied to the MSB it yields the magnitude.
// Latency: purely combinational.
// Backpressure: none, no state.
module multdiv_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_in,
  input  logic             neg,
  output logic [WIDTH-1:0] val_out
);

  // The most-negative value maps onto itself, which is the correct unsigned magnitude.
  assign val_out = neg ? -val_in : val_in;

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed MUL (low half) / DIV (truncating) unit with tagged, held result.
// Latency: WIDTH RUN cycles + 1 FIX cycle (MUL may exit RUN early when MULTDIV_EARLY_OUT_EN is defined).
// Backpressure: result held in DONE until wb_grant; new issue accepted only while ready.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  input  logic             wb_grant,
  output logic             ready,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic [TAG_W-1:0] tag_out
);

  localparam int CW = cnt_w(WIDTH);

  state_e             state_q, state_d;
  logic               op_q, op_d;
  logic               sign_q, sign_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // MUL: left-shifting multiplicand. DIV: divisor in the low half.
  logic [2*WIDTH-1:0] mc_q, mc_d;
  // MUL: right-shifting multiplier. DIV: dividend shifting out, quotient shifting in.
  logic [WIDTH-1:0]   mp_q, mp_d;
  // MUL: product accumulator. DIV: partial remainder in the low half.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] fix_in, fix_out;
  logic [WIDTH:0]     fix_hi;
  logic               mul_ovf;
  logic [WIDTH-1:0]   mul_mp_next;
  logic [WIDTH:0]     div_shift, div_trial;
  logic               run_last;
  logic               accept;

  multdiv_abs #(.WIDTH(WIDTH)) u_abs_a (
    .val_in (operand_a),
    .neg    (operand_a[WIDTH-1]),
    .val_out(mag_a)
  );

  multdiv_abs #(.WIDTH(WIDTH)) u_abs_b (
    .val_in (operand_b),
    .neg    (operand_b[WIDTH-1]),
    .val_out(mag_b)
  );

  // Sign correction of the unsigned product (full width) or quotient (zero-extended).
  assign fix_in = (op_q == OP_MUL) ? acc_q : {{WIDTH{1'b0}}, mp_q};

  multdiv_abs #(.WIDTH(2*WIDTH)) u_abs_fix (
    .val_in (fix_in),
    .neg    (sign_q),
    .val_out(fix_out)
  );

  // Signed product fits in WIDTH bits only if its top WIDTH+1 bits are all equal.
  assign fix_hi  = fix_out[2*WIDTH-1:WIDTH-1];
  assign mul_ovf = ~((&fix_hi) | ~(|fix_hi));

  assign mul_mp_next = mp_q >> 1;
  assign div_shift   = {acc_q[WIDTH-1:0], mp_q[WIDTH-1]};
  assign div_trial   = div_shift - {1'b0, mc_q[WIDTH-1:0]};

`ifdef MULTDIV_EARLY_OUT_EN
  // MUL stops once no multiplier bits remain; always at least one RUN cycle.
  assign run_last = (cnt_q == '0) | ((op_q == OP_MUL) & (mul_mp_next == '0));
`else
  assign run_last = (cnt_q == '0);
`endif

  assign accept       = start & ~flush & ((state_q == IDLE) | ((state_q == DONE) & wb_grant));
  assign ready        = (state_q == IDLE) | ((state_q == DONE) & wb_grant & ~flush);
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result       = result_q;
  assign exception    = exc_q;
  assign tag_out      = tag_q;

  // Next-state and datapath: issue, one iteration per RUN cycle, sign fix, hold.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_d   = sign_q;
    tag_d    = tag_q;
    cnt_d    = cnt_q;
    mc_d     = mc_q;
    mp_d     = mp_q;
    acc_d    = acc_q;
    result_d = result_q;
    exc_d    = exc_q;
    if (accept) begin
      op_d   = op;
      sign_d = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
      tag_d  = tag_in;
      cnt_d  = CW'(WIDTH-1);
      acc_d  = '0;
      if (op == OP_MUL) begin
        mc_d = {{WIDTH{1'b0}}, mag_a};
        mp_d = mag_b;
      end else begin
        mc_d = {{WIDTH{1'b0}}, mag_b};
        mp_d = mag_a;
      end
      state_d = RUN;
    end else if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (op_q == OP_MUL) begin
            if (mp_q[0]) acc_d = acc_q + mc_q;
            mc_d = mc_q << 1;
            mp_d = mul_mp_next;
          end else if (!div_trial[WIDTH]) begin
            acc_d = {{WIDTH{1'b0}}, div_trial[WIDTH-1:0]};
            mp_d  = {mp_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {{WIDTH{1'b0}}, div_shift[WIDTH-1:0]};
            mp_d  = {mp_q[WIDTH-2:0], 1'b0};
          end
          if (run_last) state_d = FIX;
          else          cnt_d   = cnt_q - CW'(1);
        end
        FIX: begin
          if (op_q == OP_MUL) begin
            result_d = fix_out[WIDTH-1:0];
            exc_d    = mul_ovf;
          end else if (mc_q[WIDTH-1:0] == '0) begin
            result_d = '0;
            exc_d    = 1'b1;
          end else begin
            // Only a positive quotient of 2^(WIDTH-1) is unrepresentable (MIN / -1).
            result_d = fix_out[WIDTH-1:0];
            exc_d    = ~sign_q & mp_q[WIDTH-1];
          end
          state_d = DONE;
        end
        DONE: begin
          if (wb_grant) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers, cleared by the asynchronous reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= 1'b0;
      sign_q   <= 1'b0;
      tag_q    <= '0;
      cnt_q    <= '0;
      mc_q     <= '0;
      mp_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      tag_q    <= tag_d;
      cnt_q    <= cnt_d;
      mc_q     <= mc_d;
      mp_q     <= mp_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed and random checks of multdiv_unit against an arithmetic reference model.
// Latency: expected cycle counts come from the model (MULTDIV_EARLY_OUT_EN aware).
// Backpressure: exercises wb_grant hold, back-to-back issue, flush and reset.
module tb_multdiv_unit;

  localparam int W  = 32;
  localparam int TW = 5;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          start, op, flush, wb_grant;
  logic [W-1:0]  operand_a, operand_b;
  logic [TW-1:0] tag_in;
  logic          ready, busy, result_valid, exception;
  logic [W-1:0]  result;
  logic [TW-1:0] tag_out;

  int errors = 0;
  int checks = 0;

  logic          cur_op;
  logic [W-1:0]  cur_a, cur_b;
  logic [TW-1:0] cur_tag;

  multdiv_unit #(.WIDTH(W), .TAG_W(TW)) dut (
    .clock       (clock),
    .reset       (rst_n),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .tag_in      (tag_in),
    .flush       (flush),
    .wb_grant    (wb_grant),
    .ready       (ready),
    .busy        (busy),
    .result_valid(result_valid),
    .result      (result),
    .exception   (exception),
    .tag_out     (tag_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision signed arithmetic, then the exception rules.
  function automatic void model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic e);
    longint p;
    int     q;
    if (o == 1'b0) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[W-1:0];
      e = (p != longint'($signed(p[W-1:0])));
    end else if (b == '0) begin
      r = '0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = a;
      e = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      r = q;
      e = 1'b0;
    end
  endfunction

  function automatic int exp_lat(input logic o, input logic [W-1:0] b);
    int n;
    logic [W-1:0] mag;
    n   = W;
    mag = b[W-1] ? -b : b;
`ifdef MULTDIV_EARLY_OUT_EN
    if (o == 1'b0) begin
      n = 0;
      while (mag != '0) begin
        n++;
        mag = mag >> 1;
      end
      if (n < 1) n = 1;
    end
`endif
    return n + 1;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return W'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] t);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk("issue_ready", ready, 1'b1);
    start = 1'b1; op = o; operand_a = a; operand_b = b; tag_in = t;
    cur_op = o; cur_a = a; cur_b = b; cur_tag = t;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic await_result(input string name);
    int lat;
    logic [W-1:0] r;
    logic e;
    lat = 0;
    while (!result_valid && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    model(cur_op, cur_a, cur_b, r, e);
    chk({name, "_latency"}, lat, exp_lat(cur_op, cur_b));
    chk({name, "_result"}, result, r);
    chk({name, "_exception"}, exception, e);
    chk({name, "_tag"}, tag_out, cur_tag);
  endtask

  task automatic grant();
    wb_grant = 1'b1;
    @(posedge clock); #1;
    wb_grant = 1'b0;
    chk("grant_valid_drop", result_valid, 1'b0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_ready"}, ready, 1'b1);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_valid"}, result_valid, 1'b0);
    chk({name, "_result"}, result, '0);
    chk({name, "_exception"}, exception, 1'b0);
    chk({name, "_tag"}, tag_out, '0);
  endtask

  initial begin
    logic [W-1:0] r;
    logic e;
    logic seen;
    rst_n = 1'b0; start = 1'b0; op = 1'b0; flush = 1'b0; wb_grant = 1'b0;
    operand_a = '0; operand_b = '0; tag_in = '0;
    cur_op = 1'b0; cur_a = '0; cur_b = '0; cur_tag = '0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clock); #1;

    // Directed arithmetic cases.
    issue(1'b0, 32'd7, -32'sd6, 5'd9);      await_result("mul_7x-6");   grant();
    issue(1'b1, -32'sd43, 32'd5, 5'd3);     await_result("div_-43/5");  grant();
    issue(1'b1, 32'd100, 32'd0, 5'd4);      await_result("div_by0");    grant();
    issue(1'b0, 32'h0001_0000, 32'h0001_0000, 5'd5); await_result("mul_ovf"); grant();
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6); await_result("div_ovf"); grant();

    // Hold in DONE with no grant, then grant together with a new issue.
    issue(1'b1, 32'd1000, -32'sd7, 5'd21);
    await_result("hold");
    model(cur_op, cur_a, cur_b, r, e);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      chk("hold_valid", result_valid, 1'b1);
      chk("hold_result", result, r);
      chk("hold_tag", tag_out, 5'd21);
    end
    wb_grant = 1'b1; start = 1'b1; op = 1'b0; operand_a = 32'd3; operand_b = 32'd4; tag_in = 5'd12;
    cur_op = 1'b0; cur_a = 32'd3; cur_b = 32'd4; cur_tag = 5'd12;
    #1;
    chk("b2b_ready", ready, 1'b1);
    @(posedge clock); #1;
    wb_grant = 1'b0; start = 1'b0;
    chk("b2b_busy", busy, 1'b1);
    await_result("b2b_mul_3x4");
    grant();

    // Flush in the tenth RUN cycle: no result ever appears.
    issue(1'b1, 32'd12345, 32'd17, 5'd7);
    repeat (9) begin @(posedge clock); #1; end
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    chk("flush_run_busy", busy, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      seen = seen | result_valid;
    end
    chk("flush_run_no_valid", seen, 1'b0);

    // Flush in DONE overrides a simultaneous start.
    issue(1'b0, 32'd5, 32'd9, 5'd8);
    await_result("pre_flush_done");
    flush = 1'b1; start = 1'b1; wb_grant = 1'b1; op = 1'b0; operand_a = 32'd2; operand_b = 32'd2;
    #1;
    chk("flush_done_ready", ready, 1'b0);
    @(posedge clock); #1;
    flush = 1'b0; start = 1'b0; wb_grant = 1'b0;
    chk("flush_done_busy", busy, 1'b0);
    chk("flush_done_valid", result_valid, 1'b0);
    repeat (3) begin @(posedge clock); #1; end
    chk("flush_done_start_ignored", busy, 1'b0);

    // Asynchronous reset in the middle of RUN.
    issue(1'b0, 32'd77, 32'd88, 5'd30);
    repeat (5) begin @(posedge clock); #1; end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    #1;
    rst_n = 1'b1;
    @(posedge clock); #1;

`ifdef MULTDIV_EARLY_OUT_EN
    issue(1'b0, 32'd1000, 32'd6, 5'd2); await_result("early_out_1000x6"); grant();
`endif

    // Random operations with random writeback delay.
    for (int k = 0; k < 16; k++) begin
      int d;
      issue(1'($urandom_range(0, 1)), pick(), pick(), TW'($urandom));
      await_result("random");
      model(cur_op, cur_a, cur_b, r, e);
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        @(posedge clock); #1;
        chk("random_hold_result", result, r);
      end
      grant();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
